// File: rtl/ttlc_io_byte_master_if.sv
// ttlc_io_byte_master_if: host request/response, bus arbitration and single-bit I/O bus
interface ttlc_io_byte_master_if #(parameter int ADDR_W = 8);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [7:0]        req_wdata;
    logic              rsp_valid;
    logic [7:0]        rsp_rdata;
    logic              bus_req;
    logic              bus_gnt;
    logic [ADDR_W-1:0] io_addr;
    logic              io_write;
    logic              io_wdata;
    logic              io_rdata;
    modport master(
        input  req_valid, req_write, req_addr, req_wdata, bus_gnt, io_rdata,
        output req_ready, rsp_valid, rsp_rdata, bus_req, io_addr, io_write, io_wdata
    );
    modport slave(
        output req_valid, req_write, req_addr, req_wdata, bus_gnt, io_rdata,
        input  req_ready, rsp_valid, rsp_rdata, bus_req, io_addr, io_write, io_wdata
    );
endinterface

// File: rtl/ttlc_io_byte_master.sv
// ttlc_io_byte_master: splits a byte request into XFER_BITS single-bit I/O accesses at consecutive addresses
module ttlc_io_byte_master #(
    parameter int ADDR_W    = 8,
    parameter int XFER_BITS = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ttlc_io_byte_master_if.master   bus
);
    typedef enum logic [1:0] {IDLE, ARB, XFER, DONE} state_t;
    localparam logic [2:0] LAST = 3'(XFER_BITS - 1);
    state_t            st, st_nx;
    logic [ADDR_W-1:0] base;
    logic              wr;
    logic [7:0]        wdata, rdata, rsp_q;
    logic [2:0]        idx;
    logic              last;
    assign last = idx == LAST;
    assign bus.rsp_rdata = rsp_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) st <= IDLE;
        else        st <= st_nx;
    // The final bit is merged straight into rsp_q so the response appears in DONE itself.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            base  <= '0;
            wr    <= 1'b0;
            wdata <= '0;
            rdata <= '0;
            rsp_q <= '0;
            idx   <= '0;
        end else begin
            if (st == IDLE && bus.req_valid) begin
                base  <= bus.req_addr;
                wr    <= bus.req_write;
                wdata <= bus.req_wdata;
                rdata <= '0;
                idx   <= '0;
            end
            if (st == XFER && bus.bus_gnt) begin
                rdata[idx] <= bus.io_rdata;
                idx        <= idx + 3'd1;
                if (last) rsp_q <= rdata | (8'(bus.io_rdata) << idx);
            end
        end
    always_comb begin
        st_nx         = st;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.bus_req   = 1'b0;
        bus.io_addr   = '0;
        bus.io_write  = 1'b0;
        bus.io_wdata  = 1'b0;
        case (st)
            IDLE: begin
                bus.req_ready = rst_n;
                st_nx         = bus.req_valid ? ARB : IDLE;
            end
            ARB: begin
                bus.bus_req = 1'b1;
                st_nx       = bus.bus_gnt ? XFER : ARB;
            end
            XFER: begin
                bus.bus_req  = 1'b1;
                bus.io_addr  = base + ADDR_W'(idx);
                bus.io_wdata = wdata[idx];
                bus.io_write = wr & bus.bus_gnt;
                st_nx        = (bus.bus_gnt && last) ? DONE : XFER;
            end
            DONE: begin
                bus.rsp_valid = 1'b1;
                st_nx         = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_ttlc_io_byte_master.sv
// tb_ttlc_io_byte_master: directed and random byte transfers against a 256-bit I/O space model
module tb_ttlc_io_byte_master;
    localparam int XB = 8;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [255:0] mem, ref_mem, img;
    logic         load = 1'b0;
    logic [7:0]   last_rsp = 8'h00;
    int           checks = 0;
    int           failures = 0;
    ttlc_io_byte_master_if #(.ADDR_W(8)) bif();
    ttlc_io_byte_master #(.ADDR_W(8), .XFER_BITS(XB)) dut(.clk(clk), .rst_n(rst_n), .bus(bif.master));
    always #5 clk = ~clk;
    assign bif.io_rdata = mem[bif.io_addr];
    always @(posedge clk)
        if (load) mem <= img;
        else if (bif.io_write) mem[bif.io_addr] <= bif.io_wdata;
    task automatic tc(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic load_mem();
        img = ref_mem;
        load = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
    endtask
    // aw: ARB cycles without grant; sa/sl: grant dropped for sl cycles while at bit sa
    task automatic run(input logic w, input logic [7:0] a, input logic [7:0] d,
                       input int aw, input int sa, input int sl, input logic hold);
        int lat, k, x0;
        logic g;
        logic [7:0] exp;
        @(negedge clk);
        #1;
        tc("rsp_held", bif.rsp_rdata, last_rsp);
        tc("ready_idle", bif.req_ready, 1);
        bif.req_valid = 1'b1;
        bif.req_write = w;
        bif.req_addr  = a;
        bif.req_wdata = d;
        bif.bus_gnt   = 1'($urandom);
        exp = 8'h00;
        for (int i = 0; i < XB; i++) begin
            exp[i] = ref_mem[8'(a + i)];
            if (w) ref_mem[8'(a + i)] = d[i];
        end
        lat = XB + 2 + aw + sl;
        x0  = aw + 2;
        k   = 0;
        @(posedge clk);
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            if (!hold) begin
                bif.req_valid = 1'b0;
                bif.req_write = 1'($urandom);
                bif.req_addr  = 8'($urandom);
                bif.req_wdata = 8'($urandom);
            end
            g = !(c <= aw) && !(c >= x0 + sa && c < x0 + sa + sl);
            bif.bus_gnt = g;
            #1;
            tc("ready_busy", bif.req_ready, 0);
            tc("rsp_valid", bif.rsp_valid, c == lat);
            tc("bus_req", bif.bus_req, c < lat);
            if (c >= x0 && c < lat) begin
                tc("io_write", bif.io_write, w & g);
                tc("io_addr", bif.io_addr, 8'(a + k));
                tc("io_wdata", bif.io_wdata, d[k]);
                if (g) k++;
            end else
                tc("io_quiet", {bif.io_write, bif.io_addr, bif.io_wdata}, 0);
        end
        tc("rsp_rdata", bif.rsp_rdata, exp);
        tc("mem_image", mem === ref_mem, 1);
        last_rsp = exp;
    endtask
    initial begin
        bif.req_valid = 1'b0;
        bif.req_write = 1'b0;
        bif.req_addr  = 8'h00;
        bif.req_wdata = 8'h00;
        bif.bus_gnt   = 1'b1;
        ref_mem = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        #1;
        tc("rst_ready", bif.req_ready, 0);
        tc("rst_outs", {bif.rsp_valid, bif.rsp_rdata, bif.bus_req, bif.io_addr, bif.io_write, bif.io_wdata}, 0);
        load_mem();
        @(negedge clk);
        rst_n = 1'b1;
        #1 tc("ready_after_rst", bif.req_ready, 1);
        run(1'b1, 8'h00, 8'hA5, 0, 0, 0, 1'b0);
        tc("output_pins", mem[7:0], 8'hA5);
        run(1'b1, 8'h60, 8'h3C, 0, 0, 0, 1'b0);
        run(1'b0, 8'h60, 8'h00, 0, 0, 0, 1'b0);
        tc("temp_read", last_rsp, 8'h3C);
        tc("temp_storage", mem[103:96], 8'h3C);
        run(1'b1, 8'hFC, 8'hFF, 0, 0, 0, 1'b0);
        run(1'b1, 8'h20, 8'h96, 5, 3, 2, 1'b0);
        run(1'b0, 8'h20, 8'h00, 5, 3, 2, 1'b0);
        // abort a write at bit 4 with reset
        @(negedge clk);
        bif.req_valid = 1'b1;
        bif.req_write = 1'b1;
        bif.req_addr  = 8'h10;
        bif.req_wdata = 8'hC3;
        bif.bus_gnt   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bif.req_valid = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        tc("pre_rst_addr", bif.io_addr, 8'h14);
        tc("pre_rst_write", bif.io_write, 1);
        rst_n = 1'b0;
        #1;
        tc("abort_outs", {bif.io_write, bif.bus_req, bif.req_ready, bif.rsp_valid, bif.rsp_rdata}, 0);
        for (int i = 0; i < 4; i++) ref_mem[8'(8'h10 + i)] = 1'(8'hC3 >> i);
        last_rsp = 8'h00;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tc("abort_ready", bif.req_ready, 1);
        tc("abort_mem", mem === ref_mem, 1);
        run(1'b1, 8'h10, 8'h5E, 0, 0, 0, 1'b0);
        ref_mem[135:128] = 8'h5A;
        load_mem();
        run(1'b0, 8'h80, 8'h00, 0, 0, 0, 1'b1);
        run(1'b0, 8'h80, 8'h00, 0, 0, 0, 1'b0);
        tc("port_in", last_rsp, 8'h5A);
        for (int n = 0; n < 40; n++)
            run(1'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)),
                int'($urandom_range(0, XB - 1)), int'($urandom_range(0, 2)), 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
